// File: rtl/ankka_pkg.sv
// Shared decode types: instruction formats, RV32I opcodes and the
// decoded-entry bundle passed from the decoder into the decode FIFO.
package ankka_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Widest PC an entry can carry; the top keeps PC_WIDTH <= PC_W.
  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    fmt_e            fmt;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/instruction_decode_unit_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
// slave: decode unit view; master: fetch/issue (environment) view.
interface instruction_decode_unit_if
  import ankka_pkg::*;
#(
  parameter int PC_WIDTH = 32
) ();

  logic [31:0]         in_instruction;
  logic [PC_WIDTH-1:0] in_pc;
  logic                in_valid;
  logic                fetch_enable;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [31:0]         out_imm;
  fmt_e                out_format;
  logic                out_illegal;

  modport slave (
    input  in_instruction, in_pc, in_valid, out_ready,
    output fetch_enable, out_valid, out_pc, out_opcode,
    output out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
    output out_imm, out_format, out_illegal
  );

  modport master (
    output in_instruction, in_pc, in_valid, out_ready,
    input  fetch_enable, out_valid, out_pc, out_opcode,
    input  out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
    input  out_imm, out_format, out_illegal
  );

endinterface

// File: rtl/instruction_decode_unit_decoder.sv
// Combinational RV32I field/format/immediate decoder.
// Illegal words come out as format R with a zero immediate.
module rv32i_decoder
  import ankka_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] sx;
  logic        is_u, is_j, is_i, is_s, is_b, is_r;
  logic        known, bad;

  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign sx = {32{inst[31]}};

  assign is_u = (op == OPC_LUI) || (op == OPC_AUIPC);
  assign is_j = (op == OPC_JAL);
  assign is_i = (op == OPC_JALR) || (op == OPC_LOAD) ||
                (op == OPC_OP_IMM) || (op == OPC_FENCE) ||
                (op == OPC_SYSTEM);
  assign is_s = (op == OPC_STORE);
  assign is_b = (op == OPC_BRANCH);
  assign is_r = (op == OPC_OP);

  assign known = is_u | is_j | is_i | is_s | is_b | is_r;

  // Branch funct3 010/011 are unassigned encodings.
  assign bad = (inst[1:0] != 2'b11) || !known ||
               ((op == OPC_JALR) && (f3 != 3'b000)) ||
               (is_b && (f3[2:1] == 2'b01));

  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.opcode  = op;
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.funct3  = f3;
    dec.funct7  = inst[31:25];
    dec.fmt     = FMT_R;
    dec.imm     = '0;
    dec.illegal = bad;
    if (!bad) begin
      unique case (1'b1)
        is_u: begin
          dec.fmt = FMT_U;
          dec.imm = {inst[31:12], 12'h000};
        end
        is_j: begin
          dec.fmt = FMT_J;
          dec.imm = {sx[31:21], inst[31], inst[19:12],
                     inst[20], inst[30:21], 1'b0};
        end
        is_i: begin
          dec.fmt = FMT_I;
          dec.imm = {sx[31:12], inst[31:20]};
        end
        is_s: begin
          dec.fmt = FMT_S;
          dec.imm = {sx[31:12], inst[31:25], inst[11:7]};
        end
        is_b: begin
          dec.fmt = FMT_B;
          dec.imm = {sx[31:13], inst[31], inst[7],
                     inst[30:25], inst[11:8], 1'b0};
        end
        is_r: begin
          dec.fmt = FMT_R;
          dec.imm = '0;
        end
        default: begin
          dec.fmt = FMT_R;
          dec.imm = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instruction_decode_unit.sv
// RV32I decode stage: decode FIFO, credit-based fetch throttle, RUN/HALTED FSM.
// ANKKA_DECODE_PERF_EN adds perf_decoded/perf_illegal push counters.
module instruction_decode_unit
  import ankka_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  instruction_decode_unit_if.slave bus,
  output logic halted
`ifdef ANKKA_DECODE_PERF_EN
  ,
  output logic [31:0] perf_decoded,
  output logic [31:0] perf_illegal
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e   state_q, state_d;
  decoded_t dec, head;
  decoded_t mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] credit;
  logic          run, full, valid, push, pop;

  rv32i_decoder u_dec (
    .inst (bus.in_instruction),
    .pc   (PC_W'(bus.in_pc)),
    .dec  (dec)
  );

  assign run   = (state_q == ST_RUN);
  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign push  = bus.in_valid && run && !flush && !full;
  assign pop   = valid && bus.out_ready;

  // The word in flight from the previous grant is counted as occupied.
  assign credit = (AW+2)'(count) + (AW+2)'(bus.in_valid);
  assign bus.fetch_enable = !reset && run && !flush &&
                            (credit < (AW+2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (push && dec.illegal) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    if (flush) state_d = ST_RUN;
  end

  assign halted = (state_q == ST_HALTED);

  // Empty FIFO presents an all-zero head.
  assign head = valid ? mem[rd_ptr] : '0;

  assign bus.out_valid   = valid;
  assign bus.out_pc      = head.pc[PC_WIDTH-1:0];
  assign bus.out_opcode  = head.opcode;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_imm     = head.imm;
  assign bus.out_format  = head.fmt;
  assign bus.out_illegal = head.illegal;

`ifdef ANKKA_DECODE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (push) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (dec.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (reset)
      !(bus.in_valid && run && !flush && full)
  ) else $error("decode fifo push dropped while full");

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Randomized + directed bench for instruction_decode_unit against a
// queue-based reference model of the decode stage.
module tb_instruction_decode_unit;
  import ankka_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, halted;
`ifdef ANKKA_DECODE_PERF_EN
  logic [31:0] perf_decoded, perf_illegal;
`endif

  instruction_decode_unit_if #(.PC_WIDTH(32)) bus ();

  instruction_decode_unit #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus.slave),
    .halted (halted)
`ifdef ANKKA_DECODE_PERF_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  bit          m_halted = 0;
  int unsigned m_dec = 0;
  int unsigned m_ill = 0;
  bit          auto_fetch = 0;
  bit          allow_ill = 0;
  int          rate = 100;
  logic [31:0] pc_ctr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] w,
                                     output fmt_e f,
                                     output logic [31:0] imm,
                                     output bit ill);
    logic [6:0]  op = w[6:0];
    logic [2:0]  f3 = w[14:12];
    logic [31:0] s  = w[31] ? 32'hFFFF_FFFF : 32'h0;
    ill = 0;
    f   = FMT_R;
    imm = 0;
    case (op)
      7'h37, 7'h17: begin
        f = FMT_U;
        imm = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        f = FMT_J;
        imm = (s << 20) | (32'(w[19:12]) << 12) |
              (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
        f = FMT_I;
        imm = (s << 12) | 32'(w[31:20]);
        ill = (op == 7'h67) && (f3 != 0);
      end
      7'h23: begin
        f = FMT_S;
        imm = (s << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
      end
      7'h63: begin
        f = FMT_B;
        imm = (s << 12) | (32'(w[7]) << 11) |
              (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h33: f = FMT_R;
      default: ill = 1;
    endcase
    if (w[1:0] != 2'b11) ill = 1;
    if (ill) begin
      f = FMT_R;
      imm = 0;
    end
  endfunction

  function automatic logic [31:0] gen_inst(input bit ill_ok);
    logic [31:0] w = $urandom;
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                              7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
    int k = $urandom_range(0, 29);
    if (ill_ok && k == 0) return 32'h0;
    if (ill_ok && k == 1) return {$urandom} & 32'hFFFF_FFFC;
    w[6:0] = ops[k % 11];
    if (w[6:0] == 7'h67) w[14:12] = 3'b000;
    if (w[6:0] == 7'h63) w[14] = 1'b1;
    return w;
  endfunction

  // One clock: check DUT against the model mid-cycle, then advance it.
  task automatic tick();
    fmt_e        ef;
    logic [31:0] eimm;
    bit          eill, exp_fe, pushed, issue;
    @(negedge clk);
    exp_fe = !reset && !m_halted && !flush &&
             (q.size() + int'(bus.in_valid)) < DEPTH;
    chk("fetch_enable", bus.fetch_enable, exp_fe);
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("halted", halted, m_halted);
    if (q.size() != 0) begin
      ref_decode(q[0].inst, ef, eimm, eill);
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_opcode", bus.out_opcode, q[0].inst[6:0]);
      chk("out_rd", bus.out_rd, q[0].inst[11:7]);
      chk("out_rs1", bus.out_rs1, q[0].inst[19:15]);
      chk("out_rs2", bus.out_rs2, q[0].inst[24:20]);
      chk("out_funct3", bus.out_funct3, q[0].inst[14:12]);
      chk("out_funct7", bus.out_funct7, q[0].inst[31:25]);
      chk("out_imm", bus.out_imm, eimm);
      chk("out_format", bus.out_format, ef);
      chk("out_illegal", bus.out_illegal, eill);
    end
`ifdef ANKKA_DECODE_PERF_EN
    chk("perf_decoded", perf_decoded, m_dec);
    chk("perf_illegal", perf_illegal, m_ill);
`endif
    if (reset) begin
      q.delete();
      m_halted = 0;
      m_dec = 0;
      m_ill = 0;
    end else if (flush) begin
      q.delete();
      m_halted = 0;
    end else begin
      pushed = bus.in_valid && !m_halted && q.size() < DEPTH;
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (pushed) begin
        ref_decode(bus.in_instruction, ef, eimm, eill);
        q.push_back('{inst: bus.in_instruction, pc: bus.in_pc});
        m_dec++;
        if (eill) begin
          m_ill++;
          m_halted = 1;
        end
      end
    end
    issue = auto_fetch && bus.fetch_enable &&
            ($urandom_range(0, 99) < rate);
    @(posedge clk);
    #1;
    if (auto_fetch) begin
      bus.in_valid = issue;
      if (issue) begin
        bus.in_instruction = gen_inst(allow_ill);
        bus.in_pc = pc_ctr;
        pc_ctr++;
      end
    end
  endtask

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    bus.in_instruction = w;
    bus.in_pc = pc;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
  endtask

  initial begin
    reset = 1;
    flush = 0;
    bus.in_valid = 0;
    bus.in_instruction = 0;
    bus.in_pc = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_enable", bus.fetch_enable, 0);
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_imm", bus.out_imm, 0);
    reset = 0;

    // Fill with ready low, then drain in order.
    auto_fetch = 1;
    rate = 100;
    allow_ill = 0;
    repeat (8) tick();
    chk("fill_valid", bus.out_valid, 1);
    chk("fill_fetch_enable", bus.fetch_enable, 0);
    chk("fill_head_pc", bus.out_pc, 0);
    bus.out_ready = 1;
    repeat (12) tick();
    auto_fetch = 0;
    bus.in_valid = 0;
    repeat (6) tick();
    chk("drain_empty", bus.out_valid, 0);
    bus.out_ready = 0;

    push_one(32'h0050_0093, 32'd100);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_opcode", bus.out_opcode, 7'h13);
    chk("addi_rd", bus.out_rd, 1);
    chk("addi_rs1", bus.out_rs1, 0);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_fmt", bus.out_format, FMT_I);
    chk("addi_illegal", bus.out_illegal, 0);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;

    push_one(32'h1234_5137, 32'd101);
    chk("lui_fmt", bus.out_format, FMT_U);
    chk("lui_rd", bus.out_rd, 2);
    chk("lui_imm", bus.out_imm, 32'h1234_5000);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    push_one(32'hFE00_0EE3, 32'd102);
    chk("beq_fmt", bus.out_format, FMT_B);
    chk("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;

    // Illegal word after two legal ones, with a word still in flight.
    push_one(32'h0050_0093, 32'd20);
    push_one(32'h0010_0113, 32'd21);
    push_one(32'hFFFF_FFFF, 32'd22);
    push_one(32'h0020_0193, 32'd23);
    chk("ill_halted", halted, 1);
    #1;
    chk("ill_fetch_enable", bus.fetch_enable, 0);
    bus.out_ready = 1;
    repeat (2) tick();
    chk("ill_head_illegal", bus.out_illegal, 1);
    chk("ill_head_pc", bus.out_pc, 22);
    tick();
    chk("ill_inflight_dropped", bus.out_valid, 0);
    bus.out_ready = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("flush_halted", halted, 0);
    chk("flush_valid", bus.out_valid, 0);
    #1;
    chk("flush_fetch_enable", bus.fetch_enable, 1);

    // Reset mid-stream.
    push_one(32'h0050_0093, 32'd30);
    push_one(32'h0050_0093, 32'd31);
    push_one(32'h0050_0093, 32'd32);
    reset = 1;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick();
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_fetch_enable", bus.fetch_enable, 0);
    reset = 0;

    // Flush beats same-cycle push and pop.
    push_one(32'h0050_0093, 32'd40);
    push_one(32'h0050_0093, 32'd41);
    flush = 1;
    bus.in_valid = 1;
    bus.out_ready = 1;
    tick();
    flush = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    chk("flush_push_pop_empty", bus.out_valid, 0);
    tick();

`ifdef ANKKA_DECODE_PERF_EN
    reset = 1;
    tick();
    reset = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 10; i++) push_one(gen_inst(0), 32'(200 + i));
    push_one(32'hFFFF_FFFF, 32'd210);
    tick();
    chk("perf_dec_11", perf_decoded, 11);
    chk("perf_ill_1", perf_illegal, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("perf_dec_flush", perf_decoded, 11);
    chk("perf_ill_flush", perf_illegal, 1);
    bus.out_ready = 0;
`endif

    auto_fetch = 1;
    allow_ill = 1;
    rate = 70;
    for (int c = 0; c < 1500; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = m_halted ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    auto_fetch = 0;
    bus.in_valid = 0;
    flush = 0;
    reset = 0;
    bus.out_ready = 1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
